// File: rtl/datamover_package.sv
// Types shared by the datamover HWPE.
// Covers streamer control and flags, the control FSM state, and the latched job configuration.
package datamover_package;

    localparam int unsigned FIELD_W = 32;

    typedef struct packed {
        logic [FIELD_W-1:0] base_addr;
        logic [FIELD_W-1:0] tot_len;
        logic [FIELD_W-1:0] d0_len;
        logic [FIELD_W-1:0] d0_stride;
        logic [FIELD_W-1:0] d1_len;
        logic [FIELD_W-1:0] d1_stride;
        logic [FIELD_W-1:0] d2_stride;
        logic [1:0]         dim_enable_1h;
    } addressgen_ctrl_t;

    typedef struct packed {
        logic             req_start;
        addressgen_ctrl_t addressgen_ctrl;
    } ctrl_sourcesink_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } flags_sourcesink_t;

    typedef struct packed {
        ctrl_sourcesink_t data_in_source_ctrl;
        ctrl_sourcesink_t data_out_sink_ctrl;
    } ctrl_streamer_t;

    typedef struct packed {
        flags_sourcesink_t data_in_source_flags;
        flags_sourcesink_t data_out_sink_flags;
        logic              tcdm_fifo_empty;
    } flags_streamer_t;

    typedef enum logic [2:0] {
        StIdle,
        StStarting,
        StWorking,
        StDrain,
        StFinished
    } datamover_state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] src_addr;
        logic [FIELD_W-1:0] dst_addr;
        logic [FIELD_W-1:0] len;
        logic [FIELD_W-1:0] stride;
    } datamover_job_t;

endpackage

// File: rtl/datamover_fsm.sv
// Datamover control FSM. It launches the source and sink streamers together, then waits for both
// to finish and for the TCDM FIFO to drain, while counting the cycles the job takes.
module datamover_fsm
    import datamover_package::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [ADDR_W-1:0] stride_i,
    output ctrl_streamer_t    ctrl_streamer_o,
    input  flags_streamer_t   flags_streamer_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cycles_o
);

    datamover_state_t state_q, state_d;
    datamover_job_t   job_q, job_d;
    logic             src_done_q, src_done_d;
    logic             snk_done_q, snk_done_d;
    logic [CNT_W-1:0] cycles_q, cycles_d, cycles_inc;
    logic             req_start;
    logic             both_ready;

    assign both_ready = flags_streamer_i.data_in_source_flags.ready_start &
                        flags_streamer_i.data_out_sink_flags.ready_start;
    assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        job_d      = job_q;
        src_done_d = src_done_q;
        snk_done_d = snk_done_q;
        cycles_d   = cycles_q;
        req_start  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    cycles_d   = '0;
                    src_done_d = 1'b0;
                    snk_done_d = 1'b0;
                    if (len_i != '0) begin
                        state_d        = StStarting;
                        job_d.src_addr = FIELD_W'(src_addr_i);
                        job_d.dst_addr = FIELD_W'(dst_addr_i);
                        job_d.len      = FIELD_W'(len_i);
                        job_d.stride   = FIELD_W'(stride_i);
                    end else begin
                        state_d = StFinished;
                    end
                end
            end
            StStarting: begin
                cycles_d = cycles_inc;
                // Both streamers are launched in the same cycle or not at all.
                if (both_ready) begin
                    req_start = 1'b1;
                    state_d   = StWorking;
                end
            end
            StWorking: begin
                cycles_d   = cycles_inc;
                src_done_d = src_done_q | flags_streamer_i.data_in_source_flags.done;
                snk_done_d = snk_done_q | flags_streamer_i.data_out_sink_flags.done;
                if (src_done_d && snk_done_d) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                cycles_d = cycles_inc;
                if (flags_streamer_i.tcdm_fifo_empty) begin
                    state_d = StFinished;
                end
            end
            StFinished: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            job_q      <= '0;
            src_done_q <= 1'b0;
            snk_done_q <= 1'b0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            job_q      <= job_d;
            src_done_q <= src_done_d;
            snk_done_q <= snk_done_d;
            cycles_q   <= cycles_d;
        end
    end

    // 1-D pattern: only dimension 0 is configured; higher dimensions stay zero.
    always_comb begin
        ctrl_streamer_o = '0;
        ctrl_streamer_o.data_in_source_ctrl.req_start                 = req_start;
        ctrl_streamer_o.data_in_source_ctrl.addressgen_ctrl.base_addr = job_q.src_addr;
        ctrl_streamer_o.data_in_source_ctrl.addressgen_ctrl.tot_len   = job_q.len;
        ctrl_streamer_o.data_in_source_ctrl.addressgen_ctrl.d0_len    = job_q.len;
        ctrl_streamer_o.data_in_source_ctrl.addressgen_ctrl.d0_stride = job_q.stride;
        ctrl_streamer_o.data_out_sink_ctrl.req_start                  = req_start;
        ctrl_streamer_o.data_out_sink_ctrl.addressgen_ctrl.base_addr  = job_q.dst_addr;
        ctrl_streamer_o.data_out_sink_ctrl.addressgen_ctrl.tot_len    = job_q.len;
        ctrl_streamer_o.data_out_sink_ctrl.addressgen_ctrl.d0_len     = job_q.len;
        ctrl_streamer_o.data_out_sink_ctrl.addressgen_ctrl.d0_stride  = job_q.stride;
    end

    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StFinished);
    assign cycles_o = cycles_q;

endmodule

// File: doc/datamover_fsm.md
# datamover_fsm

Control engine of the datamover HWPE. It accepts a job from the register-file/control slave, then drives both streamers through `datamover_package::ctrl_streamer_t`: the `data_in` source (TCDM read) and the `data_out` sink (TCDM write). It consumes `datamover_package::flags_streamer_t` and signals job completion only after both streamers report done and the TCDM FIFO has drained. It also keeps a per-job cycle counter.

## Interface
Parameters:
- `ADDR_W`, default 32: TCDM byte-address width.
- `LEN_W`, default 16: job length width, in 32-bit words.
- `CNT_W`, default 32: width of the cycle counter.

Ports:
- `clk_i`  in  1: clock. All logic is on the rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `start_i`  in  1: job-start pulse. It is sampled only in IDLE.
- `src_addr_i`  in  ADDR_W: source base byte address.
- `dst_addr_i`  in  ADDR_W: destination base byte address.
- `len_i`  in  LEN_W: number of words to move.
- `stride_i`  in  ADDR_W: byte stride between words. 4 means contiguous.
- `ctrl_streamer_o`  out  `ctrl_streamer_t`: source and sink streamer control.
- `flags_streamer_i`  in  `flags_streamer_t`: streamer flags and `tcdm_fifo_empty`.
- `busy_o`  out  1: high in every state except IDLE.
- `done_o`  out  1: one-cycle completion pulse.
- `cycles_o`  out  CNT_W: cycles spent by the last or current job.

## Operation
States:
- **IDLE → STARTING**: on `start_i` with `len_i != 0`. In that cycle the block latches `src_addr_i`, `dst_addr_i`, `len_i` and `stride_i`, and clears `cycles_o` and both sticky done bits.
- **IDLE → FINISHED**: on `start_i` with `len_i == 0`. Neither streamer receives `req_start`.
- **STARTING**:
  - `req_start` of both streamers is asserted combinationally, in the same cycle, only when `data_in_source_flags.ready_start` and `data_out_sink_flags.ready_start` are both 1.
  - In that cycle the block moves to WORKING.
  - If only one streamer is ready, neither gets `req_start`. Each streamer sees exactly one `req_start` per job.
- **WORKING**:
  - Sticky bit `src_done_q` is set by `data_in_source_flags.done`.
  - Sticky bit `snk_done_q` is set by `data_out_sink_flags.done`.
  - Done pulses may arrive in the same cycle or in any order.
  - Move to DRAIN in the cycle after both sticky bits are 1, or in the same cycle if the final pulse completes the pair (use the next-value of the sticky bits).
- **DRAIN → FINISHED**: when `tcdm_fifo_empty` is 1.
- **FINISHED → IDLE**: unconditional. `done_o` is 1 for exactly this one cycle.

Address-generator configuration, per streamer:
- `base_addr` is the latched src or dst address.
- `tot_len` and `d0_len` are the latched `len_i`, zero-extended.
- `d0_stride` is the latched `stride_i`.
- `d1_len`, `d1_stride`, `d2_stride` are 0.
- `dim_enable_1h` is 0, giving a 1-D access pattern.

These fields come from registers. They are stable from the cycle after acceptance until the return to IDLE.

Cycle counter:
- `cycles_o` increments in STARTING, WORKING and DRAIN.
- It saturates at 2^CNT_W−1.
- It holds its value in IDLE and FINISHED.

Input rules:
- `start_i` is ignored in every state other than IDLE.
- Done flags seen outside WORKING are ignored.

## Timing
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `cycles_o`=0, all `ctrl_streamer_o` fields 0, sticky bits 0.
- Reset mid-job returns the block to IDLE in the next cycle. No `done_o` is issued and no `req_start` is re-issued.
- Best case, with both streamers ready and an immediate done: `start_i` at cycle 0, `req_start` at cycle 1, done pulses at cycle k, `done_o` at cycle k+2 when the FIFO is already empty.
- `busy_o` rises the cycle after `start_i` and falls the cycle after `done_o`.
- For `len_i`=0: `start_i` at cycle 0, `done_o` at cycle 1, `cycles_o`=0.

## Structure
- `datamover_package` gains two items:
  - the state enum `datamover_state_t` (IDLE, STARTING, WORKING, DRAIN, FINISHED);
  - a job-config struct `datamover_job_t` (addresses, length, stride).
- No sub-module is needed. The block is a single FSM plus a config register, two sticky bits and a counter.

## Test plan
- Basic job:
  - Stimulus: len=16, src=0x100, dst=0x400, stride=4, both streamers ready, both done at cycle 20, FIFO empty.
  - Required: `req_start` on both at cycle 1; `tot_len`=16 on both; `done_o` at cycle 22; `cycles_o`=21.
- Zero length:
  - Stimulus: len=0.
  - Required: `done_o` at cycle 1; no `req_start`; `cycles_o`=0.
- Staggered ready:
  - Stimulus: source `ready_start` high from cycle 1, sink from cycle 5.
  - Required: a single `req_start` on both streamers at cycle 5 only.
- Split done plus drain:
  - Stimulus: source done at cycle 10, sink done at cycle 30, `tcdm_fifo_empty` low until cycle 40.
  - Required: DRAIN entered at cycle 31; `done_o` at cycle 41.
- Reset mid-job:
  - Stimulus: `rst_i` in WORKING.
  - Required: all outputs return to their reset values the next cycle; no `done_o`.
- Start while busy:
  - Stimulus: `start_i` with new config in WORKING.
  - Required: ignored; config fields stay unchanged and exactly one `done_o` is produced.
